// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state type, rst_count saturation limit and saturating increment for rst_seq.
package rst_seq_pkg;
`include "rst_seq_defs.vh"
    typedef enum logic [1:0] {
        ST_ASSERT  = `ST_ASSERT,
        ST_HOLD    = `ST_HOLD,
        ST_RELEASE = `ST_RELEASE,
        ST_RUN     = `ST_RUN
    } state_t;
    localparam logic [7:0] RST_COUNT_MAX = `RST_COUNT_MAX;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v == RST_COUNT_MAX ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/rst_seq_if.sv
// rst_seq_if: reset-request inputs and reset outputs of rst_seq.
//   btn_rst/locked: raw asynchronous request and clock-good flag
//   rst_out/ready/rst_count: registered domain resets, all-released flag, re-entry count
//   master = board side, slave = rst_seq
interface rst_seq_if #(parameter int NUM_DOMAINS = 3);
    logic                   btn_rst;
    logic                   locked;
    logic [NUM_DOMAINS-1:0] rst_out;
    logic                   ready;
    logic [7:0]             rst_count;
    modport master (output btn_rst, locked, input rst_out, ready, rst_count);
    modport slave  (input btn_rst, locked, output rst_out, ready, rst_count);
endinterface

// File: rtl/rst_seq_defs.vh
// rst_seq_defs: FSM state encodings and the rst_count saturation value shared by the rst_seq slice.
`ifndef RST_SEQ_DEFS_VH
`define RST_SEQ_DEFS_VH
`define ST_ASSERT     2'd0
`define ST_HOLD       2'd1
`define ST_RELEASE    2'd2
`define ST_RUN        2'd3
`define RST_COUNT_MAX 8'd255
`endif

// File: rtl/sync_debounce.sv
// sync_debounce: STAGES-flop synchronizer followed by an optional debounce filter.
//   clk/rst: clock and synchronous active-high reset
//   din: asynchronous input; dout: synchronized (and debounced) output
//   DEBOUNCE_CYCLES=0 gives a plain synchronizer
module sync_debounce #(
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic [STAGES-1:0] sync;
    always_ff @(posedge clk)
        sync <= rst ? '0 : {sync[STAGES-2:0], din};
    if (DEBOUNCE_CYCLES == 0) begin : g_sync
        assign dout = sync[STAGES-1];
    end else begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             deb;
        // the output follows only after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                deb <= 1'b0;
            end else if (sync[STAGES-1] == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                deb <= sync[STAGES-1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign dout = deb;
    end
endmodule

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer holding reset after clock-good, then releasing domains in staggered order.
//   clk/rst: buffered global clock and synchronous active-high reset
//   bus (slave): btn_rst/locked in; rst_out/ready/rst_count out (all registered)
module rst_seq import rst_seq_pkg::*; #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int HOLD_CYCLES     = 256,
    parameter int NUM_DOMAINS     = 3,
    parameter int STAGGER_CYCLES  = 16,
    parameter int CNT_W           = 16
) (
    input logic     clk,
    input logic     rst,
    rst_seq_if.slave bus
);
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [NUM_DOMAINS-1:0] rst_out, rst_out_n;
    logic                   ready, ready_n;
    logic [7:0]             rst_count, rst_count_n;
    logic                   btn_deb, locked_s, fault, step;
    sync_debounce #(.STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn (
        .clk(clk), .rst(rst), .din(bus.btn_rst), .dout(btn_deb)
    );
    sync_debounce #(.STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0), .CNT_W(CNT_W)) u_locked (
        .clk(clk), .rst(rst), .din(bus.locked), .dout(locked_s)
    );
    assign fault = btn_deb | ~locked_s;
    // end of the current HOLD period or stagger gap
    assign step = cnt == CNT_W'((state == ST_HOLD ? HOLD_CYCLES : STAGGER_CYCLES) - 1);
    // rst_out doubles as the stagger index: each release shifts one more zero in from bit 0
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rst_out_n   = rst_out;
        ready_n     = ready;
        rst_count_n = rst_count;
        if (state == ST_ASSERT) begin
            state_n = fault ? ST_ASSERT : ST_HOLD;
        end else if (fault) begin
            state_n     = ST_ASSERT;
            cnt_n       = '0;
            rst_out_n   = '1;
            ready_n     = 1'b0;
            rst_count_n = sat_inc(rst_count);
        end else if (state != ST_RUN) begin
            cnt_n = step ? '0 : cnt + CNT_W'(1);
            if (step) begin
                rst_out_n = rst_out << 1;
                ready_n   = rst_out_n == '0;
                state_n   = ready_n ? ST_RUN : ST_RELEASE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            rst_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rst_out   <= rst_out_n;
            ready     <= ready_n;
            rst_count <= rst_count_n;
        end
    end
    assign bus.rst_out   = rst_out;
    assign bus.ready     = ready;
    assign bus.rst_count = rst_count;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: self-checking bench for rst_seq with a cycle-stamped expectation scoreboard.
module tb_rst_seq;
    typedef struct {
        int         cyc;
        logic [2:0] rst_out;
        logic       ready;
        logic [7:0] cnt;
        string      name;
    } sb_t;
    typedef struct {
        int         rel;
        logic [2:0] rst_out;
        logic       ready;
        logic [7:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    sb_t  sb[$];
    sb_t  e;
    vec_t cold[10];

    rst_seq_if #(.NUM_DOMAINS(3)) bus ();

    rst_seq #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(4),
        .NUM_DOMAINS(3), .STAGGER_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc || bus.rst_out !== e.rst_out || bus.ready !== e.ready || bus.rst_count !== e.cnt)
            begin
                n_fail++;
                $display("FAIL %s @cycle %0d (due %0d): got rst_out=%b ready=%b rst_count=%0d, want rst_out=%b ready=%b rst_count=%0d",
                         e.name, cyc, e.cyc, bus.rst_out, bus.ready, bus.rst_count, e.rst_out, e.ready, e.cnt);
            end
        end
    end

    task automatic go(input int abs);
        while (cyc < abs) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp(input int c, input logic [2:0] r, input logic rd, input logic [7:0] n, input string nm);
        sb.push_back('{c, r, rd, n, nm});
    endtask

    int t0, t, u, a0, v;

    initial begin
        cold[0] = '{0,  3'b111, 1'b0, 8'd0};
        cold[1] = '{2,  3'b111, 1'b0, 8'd0};
        cold[2] = '{6,  3'b111, 1'b0, 8'd0};
        cold[3] = '{7,  3'b110, 1'b0, 8'd0};
        cold[4] = '{8,  3'b110, 1'b0, 8'd0};
        cold[5] = '{9,  3'b100, 1'b0, 8'd0};
        cold[6] = '{10, 3'b100, 1'b0, 8'd0};
        cold[7] = '{11, 3'b000, 1'b1, 8'd0};
        cold[8] = '{12, 3'b000, 1'b1, 8'd0};
        cold[9] = '{15, 3'b000, 1'b1, 8'd0};
        bus.btn_rst = 1'b0;
        bus.locked  = 1'b1;
        exp(3, 3'b111, 1'b0, 8'd0, "in_reset");
        go(5);
        t0 = cyc;
        for (int i = 0; i < 10; i++)
            exp(t0 + cold[i].rel, cold[i].rst_out, cold[i].ready, cold[i].cnt, $sformatf("cold_start_%0d", cold[i].rel));
        rst = 1'b0;
        go(t0 + 16);

        t = cyc;
        exp(t + 11, 3'b000, 1'b1, 8'd0, "glitch_ignored");
        exp(t + 15, 3'b000, 1'b1, 8'd0, "glitch_ignored_late");
        bus.btn_rst = 1'b1;
        go(t + 5);
        bus.btn_rst = 1'b0;
        go(t + 20);

        t = cyc;
        exp(t + 10, 3'b000, 1'b1, 8'd0, "press_before_latency");
        exp(t + 11, 3'b111, 1'b0, 8'd1, "press_assert");
        exp(t + 34, 3'b111, 1'b0, 8'd1, "press_hold_end");
        exp(t + 35, 3'b110, 1'b0, 8'd1, "press_rel0");
        exp(t + 37, 3'b100, 1'b0, 8'd1, "press_rel1");
        exp(t + 38, 3'b100, 1'b0, 8'd1, "press_rel1_hold");
        exp(t + 39, 3'b000, 1'b1, 8'd1, "press_ready");
        bus.btn_rst = 1'b1;
        go(t + 20);
        bus.btn_rst = 1'b0;
        go(t + 45);

        t = cyc;
        exp(t + 2,  3'b000, 1'b1, 8'd1, "lock_loss_before");
        exp(t + 3,  3'b111, 1'b0, 8'd2, "lock_loss_assert");
        exp(t + 12, 3'b111, 1'b0, 8'd2, "relock_hold");
        exp(t + 13, 3'b110, 1'b0, 8'd2, "relock_rel0");
        exp(t + 17, 3'b000, 1'b1, 8'd2, "relock_ready");
        bus.locked = 1'b0;
        go(t + 6);
        bus.locked = 1'b1;
        go(t + 20);

        t = cyc;
        u = t + 1;
        exp(u,      3'b111, 1'b0, 8'd0, "sync_rst_mid_run");
        exp(u + 7,  3'b110, 1'b0, 8'd0, "midrel_rel0");
        exp(u + 9,  3'b100, 1'b0, 8'd0, "midrel_rel1");
        exp(u + 10, 3'b111, 1'b0, 8'd1, "midrel_reassert");
        exp(u + 15, 3'b111, 1'b0, 8'd1, "midrel_no_partial");
        exp(u + 27, 3'b000, 1'b1, 8'd1, "midrel_recover");
        rst = 1'b1;
        go(u);
        rst = 1'b0;
        go(u + 7);
        bus.locked = 1'b0;
        go(u + 16);
        bus.locked = 1'b1;
        go(u + 30);

        a0 = cyc;
        exp(a0 + 39,   3'b111, 1'b0, 8'd11,  "sat_count_11");
        exp(a0 + 1015, 3'b111, 1'b0, 8'd255, "sat_reach_255");
        exp(a0 + 1039, 3'b111, 1'b0, 8'd255, "sat_hold_255");
        exp(a0 + 1048, 3'b000, 1'b1, 8'd255, "sat_ready");
        for (int i = 0; i < 260; i++) begin
            go(a0 + 4 * i);
            bus.locked = 1'b0;
            go(a0 + 4 * i + 1);
            bus.locked = 1'b1;
        end
        go(a0 + 1050);

        v = cyc;
        exp(v + 1,  3'b111, 1'b0, 8'd0, "rst_clears_count");
        exp(v + 12, 3'b000, 1'b1, 8'd0, "rst_restart_ready");
        rst = 1'b1;
        go(v + 1);
        rst = 1'b0;
        go(v + 14);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer directly downstream of the board clock input buffer. Runs on the buffered global clock `clk`.
- Synchronizes and debounces an external reset request and a clock-good indication.
- Holds the design in reset for a programmable time after the clock is good and the request clears.
- Releases NUM_DOMAINS reset outputs in a staggered order, then flags `ready`.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth for btn_rst and locked (min 2)
- DEBOUNCE_CYCLES, 1024, consecutive stable cycles required before the debounced btn_rst changes (min 1)
- HOLD_CYCLES, 256, cycles spent in HOLD before the first release (min 1)
- NUM_DOMAINS, 3, number of reset outputs (min 1)
- STAGGER_CYCLES, 16, cycles between successive domain releases (min 1)
- CNT_W, 16, width of the shared counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, STAGGER_CYCLES)

Ports:
- clk  in  1  buffered global clock; the only clock
- rst  in  1  synchronous, active-high reset
- btn_rst  in  1  raw asynchronous external reset request, active-high
- locked  in  1  asynchronous clock-source-good flag; tie to 1 if no source exists
- rst_out  out  NUM_DOMAINS  active-high domain resets; bit 0 is released first
- ready  out  1  high once every domain is released
- rst_count  out  8  number of re-entries into ASSERT, saturating at 255

Behaviour:
- Reset (rst=1, dominates everything):
  - state=ASSERT, rst_out=all ones, ready=0, rst_count=0.
  - Synchronizer flops, debounce counter and debounced value cleared to 0.
- All outputs are registered.
- btn path:
  - SYNC_STAGES-flop synchronizer, then debounce.
  - btn_deb takes the synced value only after it has differed from btn_deb for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle where synced equals btn_deb clears the debounce counter.
- locked path: synchronized only (locked_s), no debounce.
- States:
  - ASSERT: rst_out all ones, ready=0. Go to HOLD when locked_s=1 and btn_deb=0.
  - HOLD: count HOLD_CYCLES cycles, then go to RELEASE. If btn_deb=1 or locked_s=0, go to ASSERT.
  - RELEASE: clear rst_out[k] STAGGER_CYCLES cycles after rst_out[k-1]. ready rises in the same cycle rst_out[NUM_DOMAINS-1] clears; that same transition enters RUN. A fault goes to ASSERT.
  - RUN: ready=1. btn_deb=1 or locked_s=0 goes to ASSERT.
- Going to ASSERT: rst_out returns to all ones and ready to 0 on the next cycle.
- Release timing (cycle 0 = first cycle with rst=0; locked=1 and btn_rst=0 throughout):
  - locked_s=1 in cycle SYNC_STAGES.
  - HOLD spans cycles S+1..S+HOLD_CYCLES.
  - rst_out[k] low from cycle S+HOLD_CYCLES+1+k*STAGGER_CYCLES.
- Fault-to-assert latency:
  - btn_rst: SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
  - locked drop: SYNC_STAGES+1 cycles.
- rst_count:
  - Increments by 1 on each transition into ASSERT from HOLD, RELEASE or RUN, saturating at 255.
  - A simultaneous btn and locked fault counts once.
  - Not incremented by rst.
- Already-released domains are re-asserted immediately on a fault during RELEASE. Partial release never persists.
- NUM_DOMAINS=1: ready rises together with rst_out[0] release.
- rst asserted mid-RELEASE or mid-RUN: the next cycle shows the full reset values listed above.

Decomposition:
- Include file rst_seq_defs.vh:
  - state encodings ST_ASSERT/ST_HOLD/ST_RELEASE/ST_RUN (2 bits)
  - rst_count saturation constant
- Sub-module sync_debounce (params STAGES, DEBOUNCE_CYCLES, CNT_W; ports clk, rst, din, dout):
  - Instantiated for btn_rst.
  - Instantiated for locked with DEBOUNCE_CYCLES=0, which means synchronize only.
- FSM, stagger index and rst_count live in rst_seq.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=4, NUM_DOMAINS=3, STAGGER_CYCLES=2):
1. Cold start: rst high 5 cycles then low, locked=1, btn_rst=0 -> rst_out=3'b111 through cycle 6; 3'b110 at 7; 3'b100 at 9; 3'b000 and ready=1 at 11; rst_count=0.
2. Button glitch: in RUN, btn_rst high 5 cycles -> rst_out stays 0, ready stays 1, rst_count=0.
3. Button press: in RUN, btn_rst high from cycle t for 20 cycles -> rst_out=3'b111 and ready=0 at t+11; rst_count=1. After release: debounce 8 cycles, then HOLD 4, then staggered release as in 1.
4. Clock loss: in RUN, locked low at cycle t -> rst_out=3'b111 at t+3; rst_count increments. locked high again -> full sequence restarts.
5. Fault mid-release: locked drops when rst_out=3'b110 -> all bits back to 1 at SYNC_STAGES+1 cycles later; rst_count=1; no partial pattern persists.
6. Saturation and sync reset: force 260 locked drops -> rst_count=255. Then rst high for 1 cycle mid-RUN -> next cycle rst_out=3'b111, ready=0, rst_count=0.
